// File: rtl/contador_bcd.sv
// contador_bcd: multi-digit BCD up/down counter with a built-in tick prescaler.
// Feeds the 7-segment decoders directly; nibble i of digits drives HEX display i.
// Priority on each edge is clr > load > step > hold. digits, tick and wrap are
// all registered, so a step taken at an edge becomes visible right after it.
module contador_bcd #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  tick,
    output logic                  wrap
);

    // A one-bit prescaler still works for PRESCALE=1: it simply stays at zero.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    // Limit a loaded nibble to a legal BCD digit so hex values never reach the displays.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'd9;
        end else begin
            return d;
        end
    endfunction

    // One BCD digit plus one, rolling 9 over to 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        if (d >= 4'd9) begin
            return 4'd0;
        end else begin
            return d + 4'd1;
        end
    endfunction

    // One BCD digit minus one, rolling 0 under to 9.
    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        if (d == 4'd0) begin
            return 4'd9;
        end else begin
            return d - 4'd1;
        end
    endfunction

    logic [PW-1:0]       pcnt_r;
    logic [4*DIGITS-1:0] digits_r;
    logic                tick_r;
    logic                wrap_r;

    logic                step_s;
    logic                carry_s;
    logic [4*DIGITS-1:0] next_s;
    logic [4*DIGITS-1:0] load_clamped_s;

    // Step strobe: the prescaler has reached its last count while enabled.
    always_comb begin
        step_s = en & (pcnt_r == PCNT_LAST);
    end

    // Ripple the +/-1 through the digits; a carry/borrow out of the top digit means wrap.
    always_comb begin
        next_s  = digits_r;
        carry_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_s) begin
                if (up) begin
                    next_s[4*i +: 4] = bcd_inc(digits_r[4*i +: 4]);
                    carry_s          = (digits_r[4*i +: 4] == 4'd9);
                end else begin
                    next_s[4*i +: 4] = bcd_dec(digits_r[4*i +: 4]);
                    carry_s          = (digits_r[4*i +: 4] == 4'd0);
                end
            end else begin
                next_s[4*i +: 4] = digits_r[4*i +: 4];
            end
        end
    end

    // Saturate every nibble of the parallel-load value to 9.
    always_comb begin
        load_clamped_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped_s[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
        end
    end

    // Count, prescaler and pulse registers with clr > load > step > hold priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_r <= '0;
            pcnt_r   <= '0;
            tick_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else if (clr) begin
            digits_r <= '0;
            pcnt_r   <= '0;
            tick_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else if (load) begin
            digits_r <= load_clamped_s;
            pcnt_r   <= '0;
            tick_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else if (step_s) begin
            digits_r <= next_s;
            pcnt_r   <= '0;
            tick_r   <= 1'b1;
            wrap_r   <= carry_s;
        end else begin
            if (en) begin
                pcnt_r <= pcnt_r + PW'(1);
            end else begin
                pcnt_r <= pcnt_r;
            end
            digits_r <= digits_r;
            tick_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end
    end

    // Outputs come straight from registers.
    assign digits = digits_r;
    assign tick   = tick_r;
    assign wrap   = wrap_r;

endmodule

// File: tb/tb_contador_bcd.sv
// Scoreboard bench for contador_bcd with DIGITS=2, PRESCALE=4.
// Stimulus pushes each expected step (value, wrap, cycle it must appear);
// a negedge monitor pops and checks whenever tick is high.
module tb_contador_bcd;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] digits;
    logic       tick;
    logic       wrap;

    int tests;
    int fails;
    int cyc;

    typedef struct {
        logic [7:0] d;
        logic       w;
        int         at;
    } exp_t;

    exp_t q[$];

    contador_bcd #(.DIGITS(2), .PRESCALE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .digits   (digits),
        .tick     (tick),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to timestamp expected ticks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_step(input logic [7:0] d, input logic w, input int at);
        exp_t e;
        e.d  = d;
        e.w  = w;
        e.at = at;
        q.push_back(e);
    endtask

    // Monitor: legal BCD every cycle, and each tick matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            tests++;
            if (digits[3:0] > 4'd9 || digits[7:4] > 4'd9) begin
                fails++;
                $display("FAIL bcd_valid: got %h", digits);
            end
            if (wrap && !tick) begin
                tests++;
                fails++;
                $display("FAIL wrap_without_tick: cycle %0d", cyc);
            end
            if (tick) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_tick: cycle %0d digits %h", cyc, digits);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    tests++;
                    if (digits !== e.d || wrap !== e.w || cyc != e.at) begin
                        fails++;
                        $display("FAIL step: got digits %h wrap %b cycle %0d expected digits %h wrap %b cycle %0d",
                                 digits, wrap, cyc, e.d, e.w, e.at);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] up_seq [10];
        up_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10};
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = 8'h00;
        clk_n(3);
        chk("reset_digits", digits, 8'h00);
        chk("reset_tick", {7'd0, tick}, 8'h00);
        chk("reset_wrap", {7'd0, wrap}, 8'h00);
        rst_n = 1'b1;
        clk_n(1);

        // Up count from zero: a step every 4th edge, 0x09 -> 0x10.
        en = 1'b1;
        up = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            expect_step(up_seq[k-1], 1'b0, cyc + 4*k);
        end
        clk_n(40);
        en = 1'b0;
        clk_n(1);
        chk("up_final", digits, 8'h10);

        // Wrap up: 0x99 -> 0x00.
        load_val = 8'h99;
        load     = 1'b1;
        en       = 1'b1;
        up       = 1'b1;
        clk_n(1);
        load = 1'b0;
        chk("load_99", digits, 8'h99);
        expect_step(8'h00, 1'b1, cyc + 4);
        clk_n(4);
        en = 1'b0;
        clk_n(1);

        // Wrap down: 0x00 -> 0x99, then a plain borrow to 0x98.
        load_val = 8'h00;
        load     = 1'b1;
        en       = 1'b1;
        up       = 1'b0;
        clk_n(1);
        load = 1'b0;
        expect_step(8'h99, 1'b1, cyc + 4);
        expect_step(8'h98, 1'b0, cyc + 8);
        clk_n(8);
        en = 1'b0;

        // Borrow across digits: 0x10 -> 0x09.
        load_val = 8'h10;
        load     = 1'b1;
        en       = 1'b1;
        clk_n(1);
        load = 1'b0;
        expect_step(8'h09, 1'b0, cyc + 4);
        clk_n(4);
        en = 1'b0;
        clk_n(1);

        // Load clamp and clr-over-load priority.
        load_val = 8'hA5;
        load     = 1'b1;
        clk_n(1);
        load = 1'b0;
        chk("load_clamp", digits, 8'h95);
        load_val = 8'h42;
        load     = 1'b1;
        clr      = 1'b1;
        clk_n(1);
        load = 1'b0;
        clr  = 1'b0;
        chk("clr_over_load", digits, 8'h00);

        // Async reset mid-count at 0x37 with the prescaler part way through.
        load_val = 8'h37;
        load     = 1'b1;
        up       = 1'b1;
        clk_n(1);
        load = 1'b0;
        chk("load_37", digits, 8'h37);
        en = 1'b1;
        clk_n(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_digits", digits, 8'h00);
        chk("async_rst_tick", {7'd0, tick}, 8'h00);
        chk("async_rst_wrap", {7'd0, wrap}, 8'h00);
        clk_n(2);
        chk("rst_held", digits, 8'h00);
        rst_n = 1'b1;
        expect_step(8'h01, 1'b0, cyc + 4);
        clk_n(4);
        en = 1'b0;

        // Enable freeze: prescaler keeps its phase across a long en=0 gap.
        clr = 1'b1;
        clk_n(1);
        clr = 1'b0;
        chk("clr", digits, 8'h00);
        en = 1'b1;
        clk_n(2);
        en = 1'b0;
        clk_n(10);
        chk("freeze_digits", digits, 8'h00);
        en = 1'b1;
        expect_step(8'h01, 1'b0, cyc + 2);
        clk_n(2);
        en = 1'b0;

        // Load mid-interval restarts the prescaler; up wiggling between steps is ignored.
        en = 1'b1;
        clk_n(2);
        load_val = 8'h20;
        load     = 1'b1;
        clk_n(1);
        load = 1'b0;
        chk("load_mid", digits, 8'h20);
        expect_step(8'h21, 1'b0, cyc + 4);
        up = 1'b0;
        clk_n(2);
        up = 1'b1;
        clk_n(2);
        en = 1'b0;

        clk_n(3);
        chk("scoreboard_drained", 8'(q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
